// File: rtl/muldiv_iter_pkg.sv
// Shared funct3 codes, FSM state encoding and operand signedness helpers for the
// iterative multiply/divide unit.
package muldiv_iter_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // MUL is treated as unsigned: the low half of the product does not depend on signedness.
  function automatic logic op_a_signed(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: word extraction, sign detection, magnitudes,
// and the divide-by-zero / signed-overflow shortcut results.
module muldiv_operand_prep
  import muldiv_iter_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            word_eff,
  output logic            a_neg,
  output logic            b_neg,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            special,
  output logic [XLEN-1:0] special_res
);

  logic [XLEN-1:0] mask_s;
  logic [XLEN-1:0] min_s;
  logic [XLEN-1:0] a_ext_s;
  logic [XLEN-1:0] b_ext_s;
  logic [XLEN-1:0] raw_s;
  logic            a_msb_s;
  logic            b_msb_s;
  logic            div_zero_s;
  logic            ovf_s;

  // Derive N-bit operand views, magnitudes and the shortcut result.
  always_comb begin
    word_eff = WORD_EN & word;
    if (word_eff) begin
      mask_s  = XLEN'(32'hFFFF_FFFF);
      min_s   = XLEN'(32'h8000_0000);
      a_msb_s = rs1[31];
      b_msb_s = rs2[31];
    end else begin
      mask_s  = {XLEN{1'b1}};
      min_s   = {1'b1, {(XLEN-1){1'b0}}};
      a_msb_s = rs1[XLEN-1];
      b_msb_s = rs2[XLEN-1];
    end
    a_ext_s = rs1 & mask_s;
    b_ext_s = rs2 & mask_s;
    a_neg   = op_a_signed(op) & a_msb_s;
    b_neg   = op_b_signed(op) & b_msb_s;
    a_mag   = a_neg ? ((~a_ext_s + XLEN'(1'b1)) & mask_s) : a_ext_s;
    b_mag   = b_neg ? ((~b_ext_s + XLEN'(1'b1)) & mask_s) : b_ext_s;

    div_zero_s = op_is_div(op) & (b_ext_s == {XLEN{1'b0}});
    ovf_s      = op_is_div(op) & op_a_signed(op) & (a_ext_s == min_s) & (b_ext_s == mask_s);
    special    = div_zero_s | ovf_s;

    // op[1] selects the remainder flavour of the divide ops.
    if (div_zero_s) begin
      raw_s = op[1] ? a_ext_s : mask_s;
    end else if (ovf_s) begin
      raw_s = op[1] ? {XLEN{1'b0}} : min_s;
    end else begin
      raw_s = {XLEN{1'b0}};
    end
    special_res = word_eff ? XLEN'(signed'(raw_s[31:0])) : raw_s;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides and flush support.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit HAS_WORD = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam bit WORD_EN = (XLEN == 64) && HAS_WORD;
  localparam int AW      = 2 * XLEN;

  muldiv_state_e   state_r;
  logic [5:0]      cnt_r;
  logic [AW-1:0]   acc_r;
  logic [XLEN-1:0] b_mag_r;
  logic [XLEN-1:0] result_r;
  logic [2:0]      op_r;
  logic            word_r;
  logic            a_neg_r;
  logic            b_neg_r;
  logic            valid_r;
  logic            ready_r;

  logic            word_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            special_s;
  logic [XLEN-1:0] special_res_s;

  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   trial_s;
  logic [AW-1:0]   mul_next_s;
  logic [AW-1:0]   div_next_s;
  logic [AW-1:0]   prod_s;
  logic [XLEN-1:0] pw_s;
  logic [XLEN-1:0] q_s;
  logic [XLEN-1:0] r_s;
  logic [XLEN-1:0] raw_s;
  logic [XLEN-1:0] fix_res_s;
  logic [5:0]      last_s;
  logic            neg_s;

  muldiv_operand_prep #(
    .XLEN    (XLEN),
    .WORD_EN (WORD_EN)
  ) u_prep (
    .op          (op_i),
    .word        (word_i),
    .rs1         (rs1_data_i),
    .rs2         (rs2_data_i),
    .word_eff    (word_s),
    .a_neg       (a_neg_s),
    .b_neg       (b_neg_s),
    .a_mag       (a_mag_s),
    .b_mag       (b_mag_s),
    .special     (special_s),
    .special_res (special_res_s)
  );

  // One iteration step of each algorithm plus the sign fix-up of the finished value.
  always_comb begin
    neg_s      = a_neg_r ^ b_neg_r;
    sum_s      = {1'b0, acc_r[AW-1:XLEN]} + (acc_r[0] ? {1'b0, b_mag_r} : {(XLEN+1){1'b0}});
    mul_next_s = {sum_s, acc_r[XLEN-1:1]};
    trial_s    = acc_r[AW-1:XLEN-1] - {1'b0, b_mag_r};
    if (trial_s[XLEN]) begin
      div_next_s = {acc_r[AW-2:0], 1'b0};
    end else begin
      div_next_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end

    // After 32 steps of an XLEN-wide shift-add the word product sits 32 bits up.
    prod_s = neg_s ? (~acc_r + AW'(1'b1)) : acc_r;
    pw_s   = neg_s ? (~acc_r[XLEN+31:32] + XLEN'(1'b1)) : acc_r[XLEN+31:32];
    q_s    = word_r ? (acc_r[XLEN-1:0] & XLEN'(32'hFFFF_FFFF)) : acc_r[XLEN-1:0];
    r_s    = acc_r[AW-1:XLEN];

    if (op_r[2]) begin
      if (op_r[1]) begin
        raw_s = a_neg_r ? (~r_s + XLEN'(1'b1)) : r_s;
      end else begin
        raw_s = neg_s ? (~q_s + XLEN'(1'b1)) : q_s;
      end
    end else if (word_r) begin
      raw_s = (op_r == OP_MUL) ? pw_s : (pw_s >> 6'd32);
    end else begin
      raw_s = (op_r == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[AW-1:XLEN];
    end
    fix_res_s = word_r ? XLEN'(signed'(raw_s[31:0])) : raw_s;
    last_s    = word_r ? 6'd31 : 6'(XLEN - 1);
  end

  // Control FSM with the iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 6'd0;
      acc_r    <= {AW{1'b0}};
      b_mag_r  <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      op_r     <= 3'd0;
      word_r   <= 1'b0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else if (flush_i) begin
      state_r  <= S_IDLE;
      cnt_r    <= 6'd0;
      result_r <= {XLEN{1'b0}};
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (valid_i && ready_r) begin
            op_r    <= op_i;
            word_r  <= word_s;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            b_mag_r <= b_mag_s;
            cnt_r   <= 6'd0;
            ready_r <= 1'b0;
            // Word dividends start at the top so the quotient lands in bits [31:0].
            acc_r   <= {{XLEN{1'b0}},
                        (word_s && op_is_div(op_i)) ? (a_mag_s << (XLEN - 32)) : a_mag_s};
            if (special_s) begin
              state_r  <= S_DONE;
              result_r <= special_res_s;
              valid_r  <= 1'b1;
            end else begin
              state_r  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_r <= op_r[2] ? div_next_s : mul_next_s;
          if (cnt_r == last_s) begin
            cnt_r   <= 6'd0;
            state_r <= S_FIX;
          end else begin
            cnt_r   <= cnt_r + 6'd1;
          end
        end
        S_FIX: begin
          result_r <= fix_res_s;
          valid_r  <= 1'b1;
          state_r  <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

  assign ready_o  = ready_r;
  assign valid_o  = valid_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (XLEN=64): results, latency,
// shortcut cases, word ops, output stall, flush and mid-operation reset.
module tb_muldiv_iter;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = 3'd0;
  logic        word_i = 1'b0;
  logic [63:0] rs1_data_i = 64'd0;
  logic [63:0] rs2_data_i = 64'd0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] result_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(64), .HAS_WORD(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .word_i     (word_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o)
  );

  // Present one request, scramble inputs after accept, wait for valid_o and consume it.
  task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    @(negedge clk);
    valid_i = 1'b1; op_i = op; word_i = w; rs1_data_i = a; rs2_data_i = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0; op_i = ~op; word_i = ~w; rs1_data_i = ~a; rs2_data_i = ~b;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (valid_o !== 1'b1 && lat < 200);
  endtask

  task automatic take_result();
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    start_op(op, w, a, b);
    wait_valid(lat);
    res = result_o;
    take_result();
  endtask

  task automatic run_table(input vec_t v[]);
    logic [63:0] r;
    int          lat;
    foreach (v[i]) begin
      do_op(v[i].op, v[i].w, v[i].a, v[i].b, r, lat);
      total++;
      if (r !== v[i].exp) begin
        bad++;
        $display("FAIL %s result got=%h exp=%h", v[i].name, r, v[i].exp);
      end
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset got ready=%b valid=%b result=%h exp 1 0 0", ready_o, valid_o, result_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_mul();
    vec_t v[] = '{
      '{"mul_7_x_m3",   OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66},
      '{"mulhu_max_sq", OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFE, 66},
      '{"mulhsu_m1_2",  OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66},
      '{"mulh_2p62_4",  OP_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 66},
      '{"mulh_m5_3",    OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66}
    };
    run_table(v);
  endtask

  task automatic test_div();
    vec_t v[] = '{
      '{"div_m7_2",   OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66},
      '{"rem_m7_2",   OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66},
      '{"divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66},
      '{"remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66},
      '{"div_7_m2",   OP_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66},
      '{"rem_7_m2",   OP_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66}
    };
    run_table(v);
  endtask

  task automatic test_special();
    vec_t v[] = '{
      '{"div_by_0",   OP_DIV,  1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{"rem_by_0",   OP_REM,  1'b0, 64'd12345, 64'd0, 64'd12345, 1},
      '{"divu_by_0",  OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{"remu_by_0",  OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1},
      '{"div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 1},
      '{"rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1}
    };
    run_table(v);
  endtask

  task automatic test_word();
    vec_t v[] = '{
      '{"divw_ovf",    OP_DIV,  1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 1},
      '{"mulw_wrap",   OP_MUL,  1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 34},
      '{"mulw_sext",   OP_MUL,  1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34},
      '{"remw_m7_2",   OP_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34},
      '{"divuw_sext",  OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hABCD_0000_0000_0001,
        64'hFFFF_FFFF_FFFF_FFFE, 34},
      '{"divuw_by_0",  OP_DIVU, 1'b1, 64'd9, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{"remuw_by_0",  OP_REMU, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000,
        64'hFFFF_FFFF_8000_0001, 1}
    };
    run_table(v);
  endtask

  task automatic test_stall();
    int lat;
    start_op(OP_DIVU, 1'b0, 64'd100, 64'd7);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_ready got=%b exp=0", ready_o);
    end
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (valid_o !== 1'b1 || result_o !== 64'd14) begin
        bad++;
        $display("FAIL stall_hold cycle %0d got valid=%b result=%h exp 1 %h", i, valid_o, result_o, 64'd14);
      end
    end
    take_result();
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got valid=%b ready=%b exp 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    int          lat;
    int          seen;
    start_op(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_calc got valid=%b ready=%b exp 0 1", valid_o, ready_o);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush_no_valid got=%0d cycles exp=0", seen);
    end

    // A flush in the same cycle as a shortcut request must win over the accept.
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = OP_DIV; word_i = 1'b0;
    rs1_data_i = 64'd3; rs2_data_i = 64'd0;
    @(posedge clk);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_beats_accept got valid=%b ready=%b exp 0 1", valid_o, ready_o);
    end

    do_op(OP_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, r, lat);
    total++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFF2 || lat !== 66) begin
      bad++;
      $display("FAIL after_flush got result=%h lat=%0d exp %h 66", r, lat, 64'hFFFF_FFFF_FFFF_FFF2);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    int          lat;
    start_op(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid got ready=%b valid=%b result=%h exp 1 0 0", ready_o, valid_o, result_o);
    end
    rst = 1'b1;
    do_op(OP_MUL, 1'b0, 64'd3, 64'd5, r, lat);
    total++;
    if (r !== 64'd15 || lat !== 66) begin
      bad++;
      $display("FAIL after_reset got result=%h lat=%0d exp %h 66", r, lat, 64'd15);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_word();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
